// File: rtl/mbledhesi_pkg.sv
// Shared constants, flag bundle and geometry check for the segmented adder pipeline.
package mbledhesi_pkg;

    localparam int DEF_WIDTH  = 24;
    localparam int DEF_STAGES = 3;

    typedef struct packed {
        logic carry;
        logic overflow;
        logic zero;
        logic negative;
    } flags_t;

    // Operands must split into whole, equal segments.
    function automatic bit geometry_ok(input int width, input int stages);
        return (stages >= 1) && ((width % stages) == 0);
    endfunction

endpackage

// File: rtl/mbledhesi_segment.sv
// Combinational SEG-bit adder slice with carry out and carry-into-MSB tap.
module mbledhesi_segment #(
    parameter int SEG = 8
) (
    input  logic [SEG-1:0] a,
    input  logic [SEG-1:0] b,
    input  logic           cin,
    output logic [SEG-1:0] s,
    output logic           cout,
    output logic           c_msb
);

    always_comb begin
        {cout, s} = {1'b0, a} + {1'b0, b} + {{SEG{1'b0}}, cin};
        // Carry into the MSB falls out of the MSB sum bit.
        c_msb = s[SEG-1] ^ a[SEG-1] ^ b[SEG-1];
    end

endmodule

// File: rtl/mbledhesi_pipeline.sv
// Pipelined adder/subtractor split into STAGES carry-registered segments with valid/ready flow.
// Subtraction is built only when MBLEDHESI_PIPELINE_SUB_EN is defined.
module mbledhesi_pipeline
    import mbledhesi_pkg::*;
#(
    parameter int WIDTH  = DEF_WIDTH,
    parameter int STAGES = DEF_STAGES
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    input  logic             op_sub,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             carryout,
    output logic             overflow,
    output logic             zero,
    output logic             negative
);

    localparam int SEG  = WIDTH / STAGES;
    localparam int LAST = STAGES - 1;
    localparam logic [WIDTH-1:0] ONES = '1;

    if (!geometry_ok(WIDTH, STAGES)) begin : g_geometry_check
        $error("mbledhesi_pipeline: WIDTH must be a multiple of STAGES");
    end

    logic             adv;
    logic [WIDTH-1:0] b_eff;
    logic             cin_eff;

`ifdef MBLEDHESI_PIPELINE_SUB_EN
    assign b_eff   = op_sub ? ~b : b;
    assign cin_eff = op_sub ? ~cin : cin;
`else
    logic op_sub_unused;
    assign op_sub_unused = op_sub;
    assign b_eff         = b;
    assign cin_eff       = cin;
`endif

    // Per-stage state: a_q/b_q carry the not-yet-added upper segments,
    // res_q carries the already-added lower segments.
    logic [STAGES-1:0] valid_q, valid_d;
    logic [STAGES-1:0] carry_q, carry_d;
    logic              cmsb_q, cmsb_d;
    logic [WIDTH-1:0]  res_q [STAGES];
    logic [WIDTH-1:0]  res_d [STAGES];
    logic [WIDTH-1:0]  a_q   [STAGES];
    logic [WIDTH-1:0]  a_d   [STAGES];
    logic [WIDTH-1:0]  b_q   [STAGES];
    logic [WIDTH-1:0]  b_d   [STAGES];

    logic [STAGES-1:0] src_v;
    logic [STAGES-1:0] src_c;
    logic [WIDTH-1:0]  src_a   [STAGES];
    logic [WIDTH-1:0]  src_b   [STAGES];
    logic [WIDTH-1:0]  src_r   [STAGES];
    logic [WIDTH-1:0]  seg_ext [STAGES];
    logic [STAGES-1:0] seg_cout;
    logic              cmsb_last;

    assign out_valid = valid_q[LAST];
    assign adv       = out_ready || !out_valid;
    assign in_ready  = adv;

    genvar gi;
    generate
        for (gi = 0; gi < STAGES; gi++) begin : g_stage
            logic [SEG-1:0] s_w;

            if (gi == 0) begin : g_src
                assign src_v[gi] = in_valid;
                assign src_c[gi] = cin_eff;
                assign src_a[gi] = a;
                assign src_b[gi] = b_eff;
                assign src_r[gi] = '0;
            end else begin : g_src
                assign src_v[gi] = valid_q[gi-1];
                assign src_c[gi] = carry_q[gi-1];
                assign src_a[gi] = a_q[gi-1];
                assign src_b[gi] = b_q[gi-1];
                assign src_r[gi] = res_q[gi-1];
            end

            if (gi == LAST) begin : g_seg
                mbledhesi_segment #(.SEG(SEG)) u_seg (
                    .a     (src_a[gi][gi*SEG +: SEG]),
                    .b     (src_b[gi][gi*SEG +: SEG]),
                    .cin   (src_c[gi]),
                    .s     (s_w),
                    .cout  (seg_cout[gi]),
                    .c_msb (cmsb_last)
                );
            end else begin : g_seg
                logic c_msb_unused;
                mbledhesi_segment #(.SEG(SEG)) u_seg (
                    .a     (src_a[gi][gi*SEG +: SEG]),
                    .b     (src_b[gi][gi*SEG +: SEG]),
                    .cin   (src_c[gi]),
                    .s     (s_w),
                    .cout  (seg_cout[gi]),
                    .c_msb (c_msb_unused)
                );
            end

            assign seg_ext[gi] = WIDTH'(s_w);
        end
    endgenerate

    always_comb begin
        valid_d = valid_q;
        carry_d = carry_q;
        cmsb_d  = cmsb_q;
        for (int k = 0; k < STAGES; k++) begin
            res_d[k] = res_q[k];
            a_d[k]   = a_q[k];
            b_d[k]   = b_q[k];
        end
        if (adv) begin
            valid_d = src_v;
            carry_d = seg_cout;
            cmsb_d  = cmsb_last;
            for (int k = 0; k < STAGES; k++) begin
                res_d[k] = (src_r[k] & ~(ONES << (k * SEG))) | (seg_ext[k] << (k * SEG));
                a_d[k]   = src_a[k] & (ONES << ((k + 1) * SEG));
                b_d[k]   = src_b[k] & (ONES << ((k + 1) * SEG));
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            valid_q <= '0;
            carry_q <= '0;
            cmsb_q  <= 1'b0;
            for (int k = 0; k < STAGES; k++) begin
                res_q[k] <= '0;
                a_q[k]   <= '0;
                b_q[k]   <= '0;
            end
        end else begin
            valid_q <= valid_d;
            carry_q <= carry_d;
            cmsb_q  <= cmsb_d;
            for (int k = 0; k < STAGES; k++) begin
                res_q[k] <= res_d[k];
                a_q[k]   <= a_d[k];
                b_q[k]   <= b_d[k];
            end
        end
    end

    flags_t flags;

    // Signed overflow is carry-into-MSB xor carry-out-of-MSB.
    always_comb begin
        flags.carry    = carry_q[LAST];
        flags.overflow = cmsb_q ^ carry_q[LAST];
        flags.zero     = (res_q[LAST] == '0);
        flags.negative = res_q[LAST][WIDTH-1];
    end

    assign sum      = res_q[LAST];
    assign carryout = flags.carry;
    assign overflow = flags.overflow;
    assign zero     = flags.zero;
    assign negative = flags.negative;

endmodule

// File: tb/tb_mbledhesi_pipeline.sv
// Scoreboard bench for mbledhesi_pipeline (3-stage and 1-stage instances).
module tb_mbledhesi_pipeline;

`ifdef MBLEDHESI_PIPELINE_SUB_EN
    localparam bit SUB_EN = 1'b1;
`else
    localparam bit SUB_EN = 1'b0;
`endif
    localparam int STAGES = 3;

    typedef struct packed {
        logic [23:0] sum;
        logic        c;
        logic        v;
        logic        z;
        logic        n;
    } res_t;

    typedef struct {
        res_t r;
        int   acc;
        bit   lat;
    } sb_t;

    logic        clk;
    logic        rst;
    logic        in_valid, in_ready, out_valid, out_ready;
    logic [23:0] a_i, b_i, sum;
    logic        cin_i, op_sub_i, carryout, overflow, zero, negative;

    logic        in_valid1, in_ready1, out_valid1, out_ready1;
    logic [23:0] a1, b1, sum1;
    logic        cin1, op_sub1, carryout1, overflow1, zero1, negative1;

    sb_t q[$];
    int  n_chk  = 0;
    int  n_fail = 0;
    int  cyc    = 0;
    int  n_txn  = 0;

    mbledhesi_pipeline #(.WIDTH(24), .STAGES(STAGES)) u_dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .a(a_i), .b(b_i), .cin(cin_i), .op_sub(op_sub_i),
        .out_valid(out_valid), .out_ready(out_ready), .sum(sum),
        .carryout(carryout), .overflow(overflow), .zero(zero), .negative(negative)
    );

    mbledhesi_pipeline #(.WIDTH(24), .STAGES(1)) u_dut1 (
        .clk(clk), .rst(rst), .in_valid(in_valid1), .in_ready(in_ready1),
        .a(a1), .b(b1), .cin(cin1), .op_sub(op_sub1),
        .out_valid(out_valid1), .out_ready(out_ready1), .sum(sum1),
        .carryout(carryout1), .overflow(overflow1), .zero(zero1), .negative(negative1)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial forever begin
        @(posedge clk);
        cyc++;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    function automatic res_t mk(input logic [23:0] s, input logic c, input logic v,
                                input logic z, input logic n);
        res_t r;
        r.sum = s; r.c = c; r.v = v; r.z = z; r.n = n;
        return r;
    endfunction

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h required %h", name, got, exp);
        end else begin
            $display("ok   %s = %h", name, got);
        end
    endtask

    // Called just after a rising edge; returns just after the accepting edge.
    task automatic issue(input logic [23:0] ia, input logic [23:0] ib, input logic icin,
                         input logic isub, input res_t e, input bit lat);
        bit acc;
        int waited;
        sb_t item;
        acc = 1'b0;
        waited = 0;
        in_valid = 1'b1; a_i = ia; b_i = ib; cin_i = icin; op_sub_i = isub;
        while (!acc && waited < 40) begin
            @(negedge clk);
            acc = in_ready;
            if (acc) begin
                item.r = e; item.acc = cyc + 1; item.lat = lat;
                q.push_back(item);
            end
            waited++;
            @(posedge clk);
            #1;
        end
        in_valid = 1'b0;
        if (!acc) begin
            n_chk++; n_fail++;
            $display("FAIL issue_timeout: in_ready stayed 0 for %0d cycles, required 1", waited);
        end
    endtask

    task automatic drain();
        int i;
        i = 0;
        while (q.size() != 0 && i < 60) begin
            @(posedge clk);
            #1;
            i++;
        end
        if (q.size() != 0) begin
            n_chk++; n_fail++;
            $display("FAIL drain_timeout: %0d results outstanding, required 0", q.size());
        end
    endtask

    // Monitor: pops on every output transfer, checks stalls for stability.
    initial begin
        res_t cur, held;
        bit   held_v;
        sb_t  e;
        held_v = 1'b0;
        held = '0;
        forever begin
            @(negedge clk);
            cur = {sum, carryout, overflow, zero, negative};
            if (rst) begin
                held_v = 1'b0;
            end else if (out_valid && out_ready) begin
                held_v = 1'b0;
                n_chk++;
                if (q.size() == 0) begin
                    n_fail++;
                    $display("FAIL unexpected_output: sum=%h appeared, required no output", sum);
                end else begin
                    e = q.pop_front();
                    n_txn++;
                    if (cur !== e.r) begin
                        n_fail++;
                        $display("FAIL txn%0d: got sum=%h c=%b v=%b z=%b n=%b required sum=%h c=%b v=%b z=%b n=%b",
                                 n_txn, cur.sum, cur.c, cur.v, cur.z, cur.n,
                                 e.r.sum, e.r.c, e.r.v, e.r.z, e.r.n);
                    end else begin
                        $display("txn%0d: sum=%h c=%b v=%b z=%b n=%b", n_txn,
                                 cur.sum, cur.c, cur.v, cur.z, cur.n);
                    end
                    if (e.lat) begin
                        n_chk++;
                        if (cyc - e.acc + 1 != STAGES) begin
                            n_fail++;
                            $display("FAIL latency txn%0d: got %0d required %0d", n_txn,
                                     cyc - e.acc + 1, STAGES);
                        end
                    end
                end
            end else if (out_valid && !out_ready) begin
                n_chk++;
                if (in_ready !== 1'b0) begin
                    n_fail++;
                    $display("FAIL stall_in_ready: got %b required 0", in_ready);
                end
                if (held_v) begin
                    n_chk++;
                    if (cur !== held) begin
                        n_fail++;
                        $display("FAIL stall_hold: got %h required %h", cur, held);
                    end
                end
                held = cur;
                held_v = 1'b1;
            end else begin
                held_v = 1'b0;
            end
        end
    end

    initial begin
        int w;
        rst = 1'b1; in_valid = 1'b0; a_i = '0; b_i = '0; cin_i = 1'b0; op_sub_i = 1'b0;
        out_ready = 1'b1;
        in_valid1 = 1'b0; a1 = '0; b1 = '0; cin1 = 1'b0; op_sub1 = 1'b0; out_ready1 = 1'b1;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;

        @(negedge clk);
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_sum", 32'(sum), 32'd0);
        chk("rst_carry", 32'(carryout), 32'd0);
        chk("rst_overflow", 32'(overflow), 32'd0);
        chk("rst_zero", 32'(zero), 32'd1);
        chk("rst_negative", 32'(negative), 32'd0);
        chk("rst_in_ready", 32'(in_ready), 32'd1);
        chk("rst1_out_valid", 32'(out_valid1), 32'd0);
        chk("rst1_zero", 32'(zero1), 32'd1);
        @(posedge clk);
        #1;

        // Directed vectors, back-to-back with no stall.
        issue(24'hFFFFFF, 24'h000001, 1'b0, 1'b0, mk(24'h000000, 1, 0, 1, 0), 1'b1);
        issue(24'h7FFFFF, 24'h000001, 1'b0, 1'b0, mk(24'h800000, 0, 1, 0, 1), 1'b1);
        issue(24'h000005, 24'h000007, 1'b0, 1'b1,
              SUB_EN ? mk(24'hFFFFFE, 0, 0, 0, 1) : mk(24'h00000C, 0, 0, 0, 0), 1'b1);
        issue(24'h00FF00, 24'h000100, 1'b1, 1'b0, mk(24'h010001, 0, 0, 0, 0), 1'b1);
        issue(24'h800000, 24'h800000, 1'b0, 1'b0, mk(24'h000000, 1, 1, 1, 0), 1'b1);
        issue(24'h000010, 24'h000001, 1'b1, 1'b1,
              SUB_EN ? mk(24'h00000E, 1, 0, 0, 0) : mk(24'h000012, 0, 0, 0, 0), 1'b1);
        drain();

        // Four back-to-back adds with a 2-cycle output stall on the first result.
        fork
            begin
                issue(24'h000001, 24'h000002, 1'b0, 1'b0, mk(24'h000003, 0, 0, 0, 0), 1'b0);
                issue(24'h0000FF, 24'h000001, 1'b0, 1'b0, mk(24'h000100, 0, 0, 0, 0), 1'b0);
                issue(24'h00FFFF, 24'h000001, 1'b0, 1'b0, mk(24'h010000, 0, 0, 0, 0), 1'b0);
                issue(24'h123456, 24'h111111, 1'b1, 1'b0, mk(24'h234568, 0, 0, 0, 0), 1'b0);
            end
            begin
                w = 0;
                while (!out_valid && w < 20) begin
                    @(posedge clk);
                    #1;
                    w++;
                end
                out_ready = 1'b0;
                repeat (2) @(posedge clk);
                #1 out_ready = 1'b1;
            end
        join
        drain();

        // Reset with three operations in flight: none may ever emerge.
        out_ready = 1'b0;
        issue(24'h111111, 24'h222222, 1'b0, 1'b0, mk(24'h333333, 0, 0, 0, 0), 1'b0);
        issue(24'h444444, 24'h111111, 1'b0, 1'b0, mk(24'h555555, 0, 0, 0, 0), 1'b0);
        issue(24'h0000AA, 24'h000055, 1'b0, 1'b0, mk(24'h0000FF, 0, 0, 0, 0), 1'b0);
        @(posedge clk);
        #1 rst = 1'b1;
        @(posedge clk);
        #1 rst = 1'b0;
        q.delete();
        @(negedge clk);
        chk("midrst_out_valid", 32'(out_valid), 32'd0);
        chk("midrst_sum", 32'(sum), 32'd0);
        chk("midrst_zero", 32'(zero), 32'd1);
        @(posedge clk);
        #1 out_ready = 1'b1;
        repeat (6) @(posedge clk);
        #1;
        issue(24'h000010, 24'h000020, 1'b1, 1'b0, mk(24'h000031, 0, 0, 0, 0), 1'b1);
        drain();

        // Single-stage instance: one-cycle registered adder.
        a1 = 24'h123456; b1 = 24'h654321; in_valid1 = 1'b1;
        @(negedge clk);
        chk("s1_in_ready", 32'(in_ready1), 32'd1);
        @(posedge clk);
        #1 in_valid1 = 1'b0;
        @(negedge clk);
        chk("s1_out_valid", 32'(out_valid1), 32'd1);
        chk("s1_sum", 32'(sum1), 32'h777777);
        chk("s1_carry", 32'(carryout1), 32'd0);
        @(posedge clk);
        #1;
        @(negedge clk);
        chk("s1_drained", 32'(out_valid1), 32'd0);

        repeat (2) @(posedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/mbledhesi_pipeline.md
# mbledhesi_pipeline

Parametrised, pipelined adder/subtractor that replaces the fixed 24-bit ripple adder in the CPU datapath. Operands are split into `STAGES` equal segments. Each segment's carry is registered into the next stage, which shortens the critical path for wider words. A valid/ready handshake on both sides supports back-to-back issue and backpressure. The block reports carry, signed overflow, zero and negative flags alongside each result.

## Interface
- `WIDTH`, 24, operand and result width in bits; must be divisible by `STAGES`
- `STAGES`, 3, number of pipeline stages (≥1); segment width `SEG = WIDTH/STAGES`
- `clk` input 1: single clock, rising edge
- `rst` input 1: synchronous, active-high reset
- `in_valid` input 1: operand set presented
- `in_ready` output 1: block accepts operands this cycle
- `a` input WIDTH: operand A
- `b` input WIDTH: operand B
- `cin` input 1: carry/borrow in
- `op_sub` input 1: 1 = subtract (see Configuration)
- `out_valid` output 1: result valid
- `out_ready` input 1: consumer accepts result
- `sum` output WIDTH: result
- `carryout` output 1: carry out of the MSB (subtract: 1 = no borrow)
- `overflow` output 1: two's-complement overflow
- `zero` output 1: `sum == 0`
- `negative` output 1: `sum[WIDTH-1]`

## Operation
- Add: `sum = a + b + cin`.
- Subtract: `sum = a + ~b + ~cin`, i.e. `a - b - cin`. `carryout` is the raw adder carry.
- `overflow = (A_msb == B'_msb) && (sum_msb != A_msb)`, where `B'` is `b` after the optional inversion.
- Stage k (0..STAGES-1) adds segment k of the operands using the carry registered by stage k-1. Stage 0 uses the effective cin.
- Upper operand segments travel forward in skew registers. Lower result segments travel forward in deskew registers. The full result is aligned at the last stage.
- Pipeline advance: `adv = out_ready || !out_valid`. All stage registers, including valid bits, shift only when `adv` is high. Bubbles are not collapsed.
- `in_ready = adv`. A transfer occurs when `in_valid && in_ready`. If `in_valid` is low while `adv` is high, a bubble (valid=0) enters stage 0.
- `zero`, `negative` and `overflow` are computed combinationally from the aligned last-stage registers.
- Results leave in issue order. There is no reordering and no drop.

## Timing
- Latency: exactly `STAGES` cycles from the accepting edge to `out_valid` high, provided there is no stall.
- Throughput: one operation per cycle while `out_ready` is high.
- With `STAGES=1` the block is a single registered adder with 1-cycle latency.
- Stall: while `out_valid && !out_ready`, all outputs hold stable and `in_ready` is 0.
- Simultaneous output accept and input accept in the same cycle is legal. No bubble is inserted.
- Reset values: `out_valid=0`, `sum=0`, `carryout=0`, `overflow=0`, `zero=1`, `negative=0`. All internal valid bits are 0.
- `in_ready` is 1 in the first cycle after reset.
- Reset asserted mid-operation discards all in-flight operations. Nothing in flight is ever emitted.

## Configuration
- Macro: `MBLEDHESI_PIPELINE_SUB_EN`.
- Defined: `op_sub` selects subtract exactly as described in Operation.
- Undefined: `op_sub` is ignored (the port remains, unused), the operation is always add, and no inversion logic is synthesised.

## Structure
- Shared package `mbledhesi_pkg`:
  - default `WIDTH`/`STAGES` constants
  - packed flag struct `{carry, overflow, zero, negative}`
  - elaboration check `WIDTH % STAGES == 0`
- Sub-module `mbledhesi_segment`: combinational `SEG`-bit adder with `cin`/`cout` and an MSB-carry-in tap for overflow. One instance per stage, produced by a generate loop.

## Test plan
All cases use WIDTH=24, STAGES=3 unless noted.
- Add `0xFFFFFF + 0x000001`, cin=0 → after 3 cycles: sum `0x000000`, carryout 1, zero 1, overflow 0.
- Add `0x7FFFFF + 0x000001` → sum `0x800000`, overflow 1, negative 1, carryout 0.
- Subtract with macro defined, `0x000005 - 0x000007`, cin=0 → sum `0xFFFFFE`, carryout 0, negative 1. Same operands without the macro → sum `0x00000C`.
- Issue 4 back-to-back adds and hold `out_ready` low for 2 cycles after the first result → `in_ready` is 0 during the stall, the held result is stable, and all 4 results emerge in order with no loss.
- Assert `rst` for one cycle with 3 operations in flight → next cycle `out_valid` is 0 and `sum` is 0; no stale result ever appears. A fresh issue then returns after 3 cycles.
- STAGES=1, `0x123456 + 0x654321` → sum `0x777777` one cycle after accept.
